// File: rtl/gen_stream_reducer_pkg.sv
// Shared types and constants for the generator stream reducer.
package gen_stream_reducer_pkg;

  localparam int GEN_W_DEFAULT = 32;
  localparam int GAP_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    DRAIN,
    REPORT
  } reducer_state_t;

endpackage

// File: rtl/gen_stream_reducer_if.sv
// Bundle of the caller-side, generator-side and result signals of the reducer.
interface gen_stream_reducer_if #(
  parameter int W     = gen_stream_reducer_pkg::GEN_W_DEFAULT,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
);

  // Handshakes: a generator tuple transfers on a cycle where gen__ready and
  // gen__valid are both 1; a result transfers on a cycle where _valid and
  // _ready are both 1, and _valid never drops before that transfer.
  logic                                        _start;
  logic [gen_stream_reducer_pkg::GAP_W-1:0]    ready_gap;
  logic                                        gen__start;
  logic                                        gen__ready;
  logic                                        gen__valid;
  logic                                        gen__done;
  logic [W-1:0]                                gen_0;
  logic [W-1:0]                                gen_1;
  logic                                        _ready;
  logic                                        _valid;
  logic                                        _done;
  logic [CNT_W-1:0]                            _count;
  logic [ACC_W-1:0]                            _sum;
  logic [W-1:0]                                _min;
  logic [W-1:0]                                _max;
  logic                                        _empty;
  gen_stream_reducer_pkg::reducer_state_t      state;

  modport master (
    input  _start, ready_gap, gen__valid, gen__done, gen_0, gen_1, _ready,
    output gen__start, gen__ready, _valid, _done, _count, _sum, _min, _max,
           _empty, state
  );

  modport slave (
    output _start, ready_gap, gen__valid, gen__done, gen_0, gen_1, _ready,
    input  gen__start, gen__ready, _valid, _done, _count, _sum, _min, _max,
           _empty, state
  );

endinterface

// File: rtl/gen_stream_reducer_throttle.sv
// Gap counter that spaces out accepted tuples; ready_ok tells the FSM whether
// gen__ready may be high in the coming cycle.
module gen_stream_reducer_throttle
  import gen_stream_reducer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             load,
  input  logic [GAP_W-1:0] ready_gap,
  output logic             ready_ok
);

  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;

  always_comb begin
    gap_next = gap_cnt;
    if (load) begin
      gap_next = '0;
    end else if (accept) begin
      gap_next = ready_gap;
    end else if (gap_cnt != '0) begin
      gap_next = gap_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_next;
    end
  end

  // Looking at the next count lets the FSM register gen__ready directly.
  assign ready_ok = (gap_next == '0);

endmodule

// File: rtl/gen_stream_reducer.sv
// Launches one generator run, drains its tuples with a throttled ready and
// reduces them to count/sum/min/max, offered as a single ready/valid result.
module gen_stream_reducer
  import gen_stream_reducer_pkg::*;
#(
  parameter int W     = GEN_W_DEFAULT,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input logic                  _clock,
  input logic                  _reset,
  gen_stream_reducer_if.master bus
);

  localparam logic [W-1:0] MAX_S = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};

  reducer_state_t   state;
  logic             gen_start_q, gen_ready_q, valid_q, done_q, empty_q;
  logic [CNT_W-1:0] count_q;
  logic [ACC_W-1:0] sum_q;
  logic [W-1:0]     min_q, max_q;
  logic [GAP_W-1:0] gap_lat;
  logic             first_drain;
  logic             accept, done_seen, ready_ok;
  logic [W:0]       pair;

  assign accept    = (state == DRAIN) && gen_ready_q && bus.gen__valid;
  // The generator may still show done from its previous run right after launch.
  assign done_seen = (state == DRAIN) && !first_drain && bus.gen__done;
  assign pair      = {bus.gen_0[W-1], bus.gen_0} + {bus.gen_1[W-1], bus.gen_1};

  gen_stream_reducer_throttle u_throttle (
    .clk       (_clock),
    .rst       (_reset),
    .accept    (accept),
    .load      (bus._start),
    .ready_gap (gap_lat),
    .ready_ok  (ready_ok)
  );

  always_ff @(posedge _clock) begin
    if (bus._start) begin
      state       <= LAUNCH;
      gen_start_q <= 1'b1;
      gen_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      min_q       <= MAX_S;
      max_q       <= MIN_S;
      empty_q     <= 1'b1;
      gap_lat     <= bus.ready_gap;
      first_drain <= 1'b1;
    end else if (_reset) begin
      state       <= IDLE;
      gen_start_q <= 1'b0;
      gen_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      min_q       <= MAX_S;
      max_q       <= MIN_S;
      empty_q     <= 1'b1;
      gap_lat     <= '0;
      first_drain <= 1'b0;
    end else begin
      gen_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        IDLE: ;
        LAUNCH: begin
          state       <= DRAIN;
          gen_ready_q <= ready_ok;
          first_drain <= 1'b1;
        end
        DRAIN: begin
          first_drain <= 1'b0;
          if (accept) begin
            if (count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
            sum_q   <= sum_q + {{(ACC_W-W-1){pair[W]}}, pair};
            if ($signed(bus.gen_0) < $signed(min_q)) min_q <= bus.gen_0;
            if ($signed(bus.gen_0) > $signed(max_q)) max_q <= bus.gen_0;
            empty_q <= 1'b0;
          end
          if (done_seen) begin
            state       <= REPORT;
            gen_ready_q <= 1'b0;
            valid_q     <= 1'b1;
          end else begin
            gen_ready_q <= ready_ok;
          end
        end
        REPORT: begin
          if (bus._ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gen__start = gen_start_q;
  assign bus.gen__ready = gen_ready_q;
  assign bus._valid     = valid_q;
  assign bus._done      = done_q;
  assign bus._count     = count_q;
  assign bus._sum       = sum_q;
  assign bus._min       = min_q;
  assign bus._max       = max_q;
  assign bus._empty     = empty_q;
  assign bus.state      = state;

endmodule
